// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_pkg                                                          |
// | Shared direction and overflow-mode encodings for mod_counter.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_gen                                                             |
// | Prescaler: tick on every PRESCALE-th enabled cycle.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, restart};
            assign tick     = en;
        end else begin : g_prescale
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] c_last = PW'(PRESCALE - 1);

            logic [PW-1:0] r_phase;
            logic          w_last;

            assign w_last = (r_phase == c_last);
            assign tick   = en && w_last;

            // Phase freezes whenever en is low so a paused count resumes mid-period.
            always_ff @(posedge clk) begin
                if (rst || restart) begin
                    r_phase <= '0;
                end else if (en) begin
                    r_phase <= w_last ? '0 : r_phase + 1'b1;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mod_counter                                                          |
// | Up/down modulo counter with load, wrap/saturate, tc and sticky flags.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mod_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int          PRESCALE  = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] max_val,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_udf;
    logic             w_tick;
    logic             w_step;
    logic [WIDTH-1:0] w_load_clamped;
    dir_e             w_dir;
    mode_e            w_mode;

    assign w_dir          = dir_e'(dir);
    assign w_mode         = mode_e'(sat_mode);
    assign w_step         = en && w_tick;
    assign w_load_clamped = (load_val > max_val) ? max_val : load_val;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (clr || load),
        .tick    (w_tick)
    );

    // Flag clear is applied first so a same-cycle terminal event wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_reset_val;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (flag_clr) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end
            if (load) begin
                r_count <= w_load_clamped;
            end else if (w_step) begin
                if (w_dir == DIR_UP) begin
                    if (r_count >= max_val) begin
                        r_count <= (w_mode == MODE_SAT) ? max_val : '0;
                        r_ovf   <= 1'b1;
                        r_tc    <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end else begin
                    if (r_count == '0) begin
                        r_count <= (w_mode == MODE_SAT) ? '0 : max_val;
                        r_udf   <= 1'b1;
                        r_tc    <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mod_counter                                                       |
// | Directed scenarios plus randomized run against a behavioural model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mod_counter;

    localparam int PS0 = 1;
    localparam int PS1 = 3;
    localparam int RV0 = 0;
    localparam int RV1 = 3;

    logic       clk;
    logic       rst, en, clr, load, dir, sat_mode, flag_clr;
    logic [3:0] load_val, max_val;
    logic [3:0] count0, count1;
    logic       tc0, ovf0, udf0, tc1, ovf1, udf1;

    int n_cmp;
    int n_bad;

    int m_count [2];
    int m_phase [2];
    bit m_tc    [2];
    bit m_ovf   [2];
    bit m_udf   [2];

    mod_counter #(.WIDTH(4), .PRESCALE(PS0), .RESET_VAL(RV0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .sat_mode(sat_mode), .max_val(max_val), .flag_clr(flag_clr),
        .count(count0), .tc(tc0), .ovf(ovf0), .udf(udf0)
    );

    mod_counter #(.WIDTH(4), .PRESCALE(PS1), .RESET_VAL(RV1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .sat_mode(sat_mode), .max_val(max_val), .flag_clr(flag_clr),
        .count(count1), .tc(tc1), .ovf(ovf1), .udf(udf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: integer counter obeying the priority rst > clr > load > step.
    function automatic void model_step(int k, int ps, int rv);
        int c;
        int mx;
        c  = m_count[k];
        mx = int'(max_val);
        if (rst) begin
            m_count[k] = rv; m_phase[k] = 0;
            m_tc[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
            return;
        end
        if (clr) begin
            m_count[k] = 0; m_phase[k] = 0;
            m_tc[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
            return;
        end
        m_tc[k] = 0;
        if (flag_clr) begin
            m_ovf[k] = 0;
            m_udf[k] = 0;
        end
        if (load) begin
            m_count[k] = (int'(load_val) > mx) ? mx : int'(load_val);
            m_phase[k] = 0;
            return;
        end
        if (!en) return;
        m_phase[k] = m_phase[k] + 1;
        if (m_phase[k] < ps) return;
        m_phase[k] = 0;
        if (dir) begin
            if (c < mx) m_count[k] = c + 1;
            else begin
                m_count[k] = sat_mode ? mx : 0;
                m_ovf[k] = 1; m_tc[k] = 1;
            end
        end else begin
            if (c > 0) m_count[k] = c - 1;
            else begin
                m_count[k] = sat_mode ? 0 : mx;
                m_udf[k] = 1; m_tc[k] = 1;
            end
        end
    endfunction

    task automatic cycle();
        model_step(0, PS0, RV0);
        model_step(1, PS1, RV1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; en = 0; clr = 0; load = 0; flag_clr = 0;
    endtask

    task automatic test_reset();
        idle();
        dir = 1; sat_mode = 0; max_val = 4'd15; load_val = 4'd0;
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        n_cmp++;
        if ({count0, tc0, ovf0, udf0} !== {4'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset dut0: got count=%0d tc=%b ovf=%b udf=%b want 0 0 0 0", count0, tc0, ovf0, udf0);
        end
        n_cmp++;
        if ({count1, tc1, ovf1, udf1} !== {4'd3, 3'b000}) begin
            n_bad++;
            $display("FAIL reset dut1: got count=%0d tc=%b ovf=%b udf=%b want 3 0 0 0", count1, tc1, ovf1, udf1);
        end
    endtask

    task automatic test_wrap_up();
        int exp_c;
        idle();
        clr = 1; cycle(); clr = 0;
        max_val = 4'd9; dir = 1; sat_mode = 0; en = 1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            exp_c = (i + 1) % 10;
            n_cmp++;
            if ({count0, tc0} !== {4'(exp_c), exp_c == 0}) begin
                n_bad++;
                $display("FAIL wrap_up step %0d: got count=%0d tc=%b want count=%0d tc=%b", i, count0, tc0, exp_c, exp_c == 0);
            end
        end
        en = 0;
        n_cmp++;
        if ({ovf0, udf0} !== 2'b10) begin
            n_bad++;
            $display("FAIL wrap_up flags: got ovf=%b udf=%b want 1 0", ovf0, udf0);
        end
    endtask

    task automatic test_sat_up();
        idle();
        flag_clr = 1; cycle(); flag_clr = 0;
        load_val = 4'd8; load = 1; cycle(); load = 0;
        n_cmp++;
        if ({count0, ovf0} !== {4'd8, 1'b0}) begin
            n_bad++;
            $display("FAIL sat_load: got count=%0d ovf=%b want 8 0", count0, ovf0);
        end
        sat_mode = 1; en = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if ({count0, tc0} !== {4'd9, i > 0}) begin
                n_bad++;
                $display("FAIL sat_up step %0d: got count=%0d tc=%b want 9 %b", i, count0, tc0, i > 0);
            end
        end
        en = 0;
        n_cmp++;
        if (ovf0 !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_ovf: got %b want 1", ovf0);
        end
        flag_clr = 1; cycle(); flag_clr = 0;
        n_cmp++;
        if ({count0, tc0, ovf0} !== {4'd9, 2'b00}) begin
            n_bad++;
            $display("FAIL sat_flag_clr: got count=%0d tc=%b ovf=%b want 9 0 0", count0, tc0, ovf0);
        end
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_c [3];
        logic       exp_t [3];
        exp_c = '{4'd0, 4'd5, 4'd4};
        exp_t = '{1'b0, 1'b1, 1'b0};
        idle();
        sat_mode = 0; dir = 0; max_val = 4'd5; load_val = 4'd1;
        load = 1; cycle(); load = 0;
        n_cmp++;
        if (count0 !== 4'd1) begin
            n_bad++;
            $display("FAIL down_load: got %0d want 1", count0);
        end
        en = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if ({count0, tc0} !== {exp_c[i], exp_t[i]}) begin
                n_bad++;
                $display("FAIL down_wrap step %0d: got count=%0d tc=%b want %0d %b", i, count0, tc0, exp_c[i], exp_t[i]);
            end
        end
        en = 0;
        n_cmp++;
        if (udf0 !== 1'b1) begin
            n_bad++;
            $display("FAIL down_udf: got %b want 1", udf0);
        end
        load_val = 4'd12; load = 1; cycle(); load = 0;
        n_cmp++;
        if ({count0, tc0} !== {4'd5, 1'b0}) begin
            n_bad++;
            $display("FAIL load_clamp: got count=%0d tc=%b want 5 0", count0, tc0);
        end
    endtask

    task automatic test_prescale();
        logic [3:0] exp_c [6];
        exp_c = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        idle();
        clr = 1; cycle(); clr = 0;
        dir = 1; max_val = 4'd15; sat_mode = 0; en = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_cmp++;
            if (count1 !== exp_c[i]) begin
                n_bad++;
                $display("FAIL prescale cycle %0d: got %0d want %0d", i, count1, exp_c[i]);
            end
        end
        cycle();
        en = 0; cycle(); cycle();
        en = 1; cycle();
        n_cmp++;
        if ({count1, tc1} !== {4'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL prescale_hold: got count=%0d tc=%b want 2 0", count1, tc1);
        end
        cycle();
        n_cmp++;
        if (count1 !== 4'd3) begin
            n_bad++;
            $display("FAIL prescale_resume: got %0d want 3", count1);
        end
        cycle();
        clr = 1; cycle(); clr = 0;
        cycle(); cycle();
        n_cmp++;
        if (count1 !== 4'd0) begin
            n_bad++;
            $display("FAIL prescale_clr_phase: got %0d want 0", count1);
        end
        cycle();
        en = 0;
        n_cmp++;
        if (count1 !== 4'd1) begin
            n_bad++;
            $display("FAIL prescale_after_clr: got %0d want 1", count1);
        end
    endtask

    task automatic test_max_lowered();
        idle();
        max_val = 4'd15; load_val = 4'd7; load = 1; cycle(); load = 0;
        max_val = 4'd4; dir = 1; sat_mode = 0; en = 1; cycle(); en = 0;
        n_cmp++;
        if ({count0, tc0, ovf0} !== {4'd0, 2'b11}) begin
            n_bad++;
            $display("FAIL lowered_up: got count=%0d tc=%b ovf=%b want 0 1 1", count0, tc0, ovf0);
        end
        max_val = 4'd15; load = 1; cycle(); load = 0;
        max_val = 4'd4; dir = 0; en = 1; cycle(); en = 0;
        n_cmp++;
        if ({count0, tc0} !== {4'd6, 1'b0}) begin
            n_bad++;
            $display("FAIL lowered_down: got count=%0d tc=%b want 6 0", count0, tc0);
        end
    endtask

    task automatic test_max_zero();
        idle();
        clr = 1; cycle(); clr = 0;
        max_val = 4'd0;
        for (int i = 0; i < 4; i++) begin
            dir = i[0]; sat_mode = i[1]; en = 1;
            cycle();
            n_cmp++;
            if ({count0, tc0} !== {4'd0, 1'b1}) begin
                n_bad++;
                $display("FAIL max_zero dir=%b sat=%b: got count=%0d tc=%b want 0 1", dir, sat_mode, count0, tc0);
            end
        end
        en = 0;
    endtask

    task automatic test_flag_set_wins();
        idle();
        clr = 1; cycle(); clr = 0;
        max_val = 4'd3; dir = 1; sat_mode = 0; load_val = 4'd3;
        load = 1; cycle(); load = 0;
        en = 1; flag_clr = 1; cycle();
        en = 0;
        n_cmp++;
        if ({count0, tc0, ovf0} !== {4'd0, 2'b11}) begin
            n_bad++;
            $display("FAIL set_wins: got count=%0d tc=%b ovf=%b want 0 1 1", count0, tc0, ovf0);
        end
        cycle(); flag_clr = 0;
        n_cmp++;
        if ({tc0, ovf0} !== 2'b00) begin
            n_bad++;
            $display("FAIL set_wins_clear: got tc=%b ovf=%b want 0 0", tc0, ovf0);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        max_val = 4'd15; load_val = 4'd9; dir = 1; sat_mode = 0;
        clr = 1; load = 1; en = 1; cycle();
        clr = 0; load = 0;
        n_cmp++;
        if ({count0, count1} !== 8'h00) begin
            n_bad++;
            $display("FAIL clr_priority: got count0=%0d count1=%0d want 0 0", count0, count1);
        end
        max_val = 4'd2;
        for (int i = 0; i < 5; i++) cycle();
        rst = 1; load = 1; cycle();
        rst = 0; load = 0; en = 0;
        n_cmp++;
        if ({count0, tc0, ovf0, udf0, count1, tc1, ovf1, udf1} !== {4'd0, 3'b000, 4'd3, 3'b000}) begin
            n_bad++;
            $display("FAIL rst_priority: got c0=%0d t0=%b o0=%b u0=%b c1=%0d t1=%b o1=%b u1=%b want 0 0 0 0 3 0 0 0",
                     count0, tc0, ovf0, udf0, count1, tc1, ovf1, udf1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) < 2);
            clr      = ($urandom_range(0, 99) < 4);
            load     = ($urandom_range(0, 99) < 8);
            flag_clr = ($urandom_range(0, 99) < 8);
            en       = ($urandom_range(0, 99) < 75);
            dir      = ($urandom_range(0, 99) < 60);
            sat_mode = ($urandom_range(0, 99) < 30);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) max_val = 4'($urandom_range(0, 15));
            cycle();
            n_cmp++;
            if ({count0, tc0, ovf0, udf0} !== {4'(m_count[0]), m_tc[0], m_ovf[0], m_udf[0]}) begin
                n_bad++;
                $display("FAIL random dut0 cycle %0d: got count=%0d tc=%b ovf=%b udf=%b want %0d %b %b %b",
                         i, count0, tc0, ovf0, udf0, m_count[0], m_tc[0], m_ovf[0], m_udf[0]);
            end
            n_cmp++;
            if ({count1, tc1, ovf1, udf1} !== {4'(m_count[1]), m_tc[1], m_ovf[1], m_udf[1]}) begin
                n_bad++;
                $display("FAIL random dut1 cycle %0d: got count=%0d tc=%b ovf=%b udf=%b want %0d %b %b %b",
                         i, count1, tc1, ovf1, udf1, m_count[1], m_tc[1], m_ovf[1], m_udf[1]);
            end
        end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0; m_phase[k] = 0;
            m_tc[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
        end
        idle();
        dir = 1; sat_mode = 0; load_val = '0; max_val = 4'd15;
        #2;
        test_reset();
        test_wrap_up();
        test_sat_up();
        test_down_wrap();
        test_prescale();
        test_max_lowered();
        test_max_zero();
        test_flag_set_wins();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
